countdown_timer_bcd: RTL

Four-digit BCD countdown timer (MM:SS) for the game's on-screen/hex-display clock. Consumes the toggling slow clock from the clock divider as a *data* input and never as a clock. It synchronizes that signal into the main `Clk` domain, edge-detects it, and prescales the edges into one-second strobes. It then decrements a loaded MM:SS value under a load/start/pause control FSM and flags expiry to game logic.

---
 rtl/countdown_timer_bcd.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/countdown_timer_bcd.sv
// Four-digit BCD MM:SS countdown timer driven by one-second strobes derived from
// a sampled slow clock, with a load/start/pause control FSM and expiry flags.
module countdown_timer_bcd #(
  parameter int unsigned TICKS_PER_SEC = 25
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Clk_slow,
  input  logic        Load,
  input  logic        Start,
  input  logic        Pause,
  input  logic [15:0] Preset,
  output logic [15:0] Digits,
  output logic        Running,
  output logic        Expired,
  output logic        Done,
  output logic        Sec_tick
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam logic [7:0] LastTick = 8'(TICKS_PER_SEC - 1);

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic        rise;
  logic        sec_strobe;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [15:0] digits_q, digits_d;
  logic [15:0] dec_value;
  logic        running_q, expired_q, done_q, tick_q;
  logic        done_d, tick_d;

  function automatic logic [15:0] clampPreset(input logic [15:0] p);
    logic [3:0] mt, mo, st, so;
    mt = (p[15:12] > 4'd9) ? 4'd9 : p[15:12];
    mo = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
    st = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    so = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return {mt, mo, st, so};
  endfunction

  // Borrow ripples upward; the FSM never strobes at 00:00, so min_tens never underflows.
  function automatic logic [15:0] bcdDecrement(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Clk_slow;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise       = s2_q & ~s3_q;
  assign sec_strobe = rise && (state_q == RUN) && (pcnt_q == LastTick);
  assign dec_value  = bcdDecrement(digits_q);

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    tick_d   = 1'b0;
    if (Load) begin
      digits_d = clampPreset(Preset);
      pcnt_d   = 8'd0;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE, PAUSED: begin
          if (Start && (digits_q != 16'h0000)) state_d = RUN;
        end
        RUN: begin
          if (rise) pcnt_d = sec_strobe ? 8'd0 : pcnt_q + 8'd1;
          if (sec_strobe) begin
            digits_d = dec_value;
            tick_d   = 1'b1;
            if (dec_value == 16'h0000) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end else if (Pause) begin
              state_d = PAUSED;
            end
          end else if (Pause) begin
            state_d = PAUSED;
          end
        end
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pcnt_q    <= 8'd0;
      digits_q  <= 16'h0000;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      digits_q  <= digits_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
      done_q    <= done_d;
      tick_q    <= tick_d;
    end
  end

  assign Digits   = digits_q;
  assign Running  = running_q;
  assign Expired  = expired_q;
  assign Done     = done_q;
  assign Sec_tick = tick_q;

endmodule
